// File: rtl/key_expansion_pkg.sv
// Shared definitions for the AES key schedule: FSM states, S-box, xtime, legal key sizes.
package key_expansion_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Legal (Nk, Nr) pairs for AES-128/192/256
   localparam int unsigned NK_128 = 4;
   localparam int unsigned NR_128 = 10;
   localparam int unsigned NK_192 = 6;
   localparam int unsigned NR_192 = 12;
   localparam int unsigned NK_256 = 8;
   localparam int unsigned NR_256 = 14;

   function automatic int unsigned nr_for_nk(input int unsigned nk);
      case (nk)
         NK_128:  return NR_128;
         NK_192:  return NR_192;
         NK_256:  return NR_256;
         default: return 0;
      endcase
   endfunction

   // AES forward S-box, entry 0 first
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Multiply by x in GF(2^8) modulo the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/key_expansion_sub_word.sv
// SubWord: S-box applied to each byte of a 32-bit word, purely combinational.
module sub_word
   import key_expansion_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub
);

   // Four independent byte lookups
   always_comb begin
      sub = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         sub[8*k +: 8] = sbox(word[8*k +: 8]);
      end
   end

endmodule

// File: rtl/key_expansion.sv
// AES key expansion: latches the cipher key on start, then produces one schedule word per clock.
module key_expansion
   import key_expansion_pkg::*;
#(
   parameter int unsigned Nk = 4,
   parameter int unsigned Nr = 10
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [32*Nk-1:0]         key_in,
   output logic                     busy,
   output logic                     done,
   output logic [128*(Nr+1)-1:0]    w
);

   localparam int unsigned   NW       = 4*(Nr+1);
   localparam int unsigned   IW       = $clog2(NW+1);
   localparam logic [IW-1:0] NW_I     = IW'(NW);
   localparam logic [IW-1:0] NK_I     = IW'(Nk);
   localparam logic [IW-1:0] LAST_I   = IW'(NW-1);
   localparam logic [2:0]    POS_LAST = 3'(Nk-1);

   state_t        state;
   state_t        state_next;
   logic          load;
   logic          step;

   logic [31:0]   words [NW];
   logic [IW-1:0] i;
   logic [2:0]    pos;        // tracks i % Nk without a divider
   logic [7:0]    rcon;

   logic [IW-1:0] prev_idx;
   logic [IW-1:0] back_idx;
   logic [31:0]   prev_word;
   logic [31:0]   back_word;
   logic [31:0]   sub_in;
   logic [31:0]   sub_out;
   logic [31:0]   temp;
   logic [31:0]   new_word;

   // State register and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == EXPAND);
         done  <= (state_next == DONE);
      end
   end

   // Next-state decode; start is only honoured outside EXPAND
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = EXPAND;
            end
         end
         EXPAND: begin
            step = 1'b1;
            if (i == LAST_I) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Source word indices, held at 0 whenever i is outside the expansion range
   always_comb begin
      prev_idx = '0;
      back_idx = '0;
      if (i >= NK_I && i < NW_I) begin
         prev_idx = i - 1'b1;
         back_idx = i - NK_I;
      end
   end

   assign prev_word = words[prev_idx];
   assign back_word = words[back_idx];

   // SubWord input: rotated word at the start of each key-length block, plain word otherwise
   always_comb begin
      sub_in = prev_word;
      if (pos == 3'd0) begin
         sub_in = {prev_word[23:0], prev_word[31:24]};
      end
   end

   sub_word u_sub_word (
      .word (sub_in),
      .sub  (sub_out)
   );

   // temp selection and the new schedule word
   always_comb begin
      temp = prev_word;
      if (pos == 3'd0) begin
         temp = sub_out ^ {rcon, 24'h0};
      end else if (Nk == 8 && pos == 3'd4) begin
         temp = sub_out;
      end
      new_word = back_word ^ temp;
   end

   // Schedule storage, word counter and round constant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < NW; k++) begin
            words[k[IW-1:0]] <= '0;
         end
         i    <= '0;
         pos  <= '0;
         rcon <= 8'h01;
      end else if (load) begin
         for (int unsigned k = 0; k < Nk; k++) begin
            words[k[IW-1:0]] <= key_in[32*(Nk-1-k) +: 32];
         end
         i    <= NK_I;
         pos  <= '0;
         rcon <= 8'h01;
      end else if (step) begin
         words[i] <= new_word;
         i        <= i + 1'b1;
         pos      <= (pos == POS_LAST) ? '0 : pos + 1'b1;
         if (pos == 3'd0) begin
            rcon <= xtime(rcon);
         end
      end
   end

   // Word 4r lands in the MSBs of round key r
   for (genvar g = 0; g < NW; g++) begin : g_w
      assign w[128*(g/4) + 32*(3 - g%4) +: 32] = words[g];
   end

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: AES-128/192/256 instances against a FIPS-197 level model.
module tb_key_expansion;

   localparam logic [255:0] K128  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [255:0] K128B = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] K192  = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [2:0] start = '0;
   logic [2:0] busy;
   logic [2:0] done;
   logic [127:0] key128 = '0;
   logic [191:0] key192 = '0;
   logic [255:0] key256 = '0;
   logic [1407:0] w128;
   logic [1663:0] w192;
   logic [1919:0] w256;
   logic [1919:0] wx [3];

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] sb [256];

   logic          m_busy [3] = '{default: 1'b0};
   logic          m_done [3] = '{default: 1'b0};
   logic          m_zero [3] = '{default: 1'b1};
   int            m_cnt  [3] = '{default: 0};
   logic [1919:0] m_full [3] = '{default: '0};
   logic [1919:0] m_w    [3] = '{default: '0};

   always #5 clk = ~clk;

   assign wx[0] = {512'b0, w128};
   assign wx[1] = {256'b0, w192};
   assign wx[2] = w256;

   key_expansion #(.Nk(4), .Nr(10)) dut128 (
      .clk(clk), .rst(rst), .start(start[0]), .key_in(key128),
      .busy(busy[0]), .done(done[0]), .w(w128));
   key_expansion #(.Nk(6), .Nr(12)) dut192 (
      .clk(clk), .rst(rst), .start(start[1]), .key_in(key192),
      .busy(busy[1]), .done(done[1]), .w(w192));
   key_expansion #(.Nk(8), .Nr(14)) dut256 (
      .clk(clk), .rst(rst), .start(start[2]), .key_in(key256),
      .busy(busy[2]), .done(done[2]), .w(w256));

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      for (int n = 0; n < 8; n++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] v, input int n);
      logic [15:0] t;
      t = {v, v} << n;
      return t[15:8];
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++) begin
            if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
         end
         sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   task automatic model_expand(input int nk, input logic [255:0] key, output logic [1919:0] flat);
      logic [31:0] wd [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nw;
      nw = 4 * (nk + 7);
      rc = 8'h01;
      for (int k = 0; k < nk; k++) wd[k] = key[32*(nk-1-k) +: 32];
      for (int k = nk; k < nw; k++) begin
         t = wd[k-1];
         if (k % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && k % nk == 4) begin
            t = subw(t);
         end
         wd[k] = wd[k-nk] ^ t;
      end
      flat = '0;
      for (int k = 0; k < nw; k++) flat[128*(k/4) + 32*(3 - k%4) +: 32] = wd[k];
   endtask

   function automatic int nk_of(input int j);
      return (j == 0) ? 4 : ((j == 1) ? 6 : 8);
   endfunction

   function automatic logic [255:0] key_of(input int j);
      case (j)
         0:       return {128'b0, key128};
         1:       return {64'b0, key192};
         default: return key256;
      endcase
   endfunction

   // Transaction-level model: expansion takes (4*(Nk+7) - Nk) clocks after acceptance
   always @(posedge clk or posedge rst) begin
      for (int j = 0; j < 3; j++) begin
         if (rst) begin
            m_busy[j] = 1'b0;
            m_done[j] = 1'b0;
            m_zero[j] = 1'b1;
            m_cnt[j]  = 0;
            m_w[j]    = '0;
         end else if (m_busy[j]) begin
            m_cnt[j] = m_cnt[j] - 1;
            if (m_cnt[j] == 0) begin
               m_busy[j] = 1'b0;
               m_done[j] = 1'b1;
               m_w[j]    = m_full[j];
            end
         end else if (start[j]) begin
            model_expand(nk_of(j), key_of(j), m_full[j]);
            m_busy[j] = 1'b1;
            m_done[j] = 1'b0;
            m_zero[j] = 1'b0;
            m_cnt[j]  = 4 * (nk_of(j) + 7) - nk_of(j);
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk_bit(input string nm, input int j, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s[%0d] at %0t: got %b expected %b", nm, j, $time, act, exp);
      end
   endtask

   task automatic chk_w(input string nm, input int j, input logic [1919:0] act, input logic [1919:0] exp);
      int r;
      vectors++;
      if (act !== exp) begin
         miscompares++;
         r = 0;
         for (int q = 14; q >= 0; q--) if (act[128*q +: 128] !== exp[128*q +: 128]) r = q;
         $display("FAIL %s[%0d] at %0t round key %0d: got %h expected %h",
                  nm, j, $time, r, act[128*r +: 128], exp[128*r +: 128]);
      end
   endtask

   task automatic chk_val(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all();
      for (int j = 0; j < 3; j++) begin
         chk_bit("busy", j, busy[j], m_busy[j]);
         chk_bit("done", j, done[j], m_done[j]);
         if (m_done[j]) chk_w("w", j, wx[j], m_w[j]);
         if (m_zero[j]) chk_w("w_zero", j, wx[j], '0);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_key(input int j, input logic [255:0] k);
      case (j)
         0:       key128 = k[127:0];
         1:       key192 = k[191:0];
         default: key256 = k;
      endcase
   endtask

   function automatic logic [255:0] junk();
      logic [255:0] v;
      for (int q = 0; q < 8; q++) v[32*q +: 32] = $urandom();
      return v;
   endfunction

   // Pulse start with key k, scramble key_in afterwards, and measure clocks until done
   task automatic run(input int j, input logic [255:0] k, input int exp_lat, input bit repulse);
      int lat;
      set_key(j, k);
      start[j] = 1'b1;
      lat = 0;
      do begin
         cycle();
         lat++;
         if (lat == 1) begin
            start[j] = 1'b0;
            set_key(j, junk());
         end
         if (repulse && lat == 10) begin
            start[j] = 1'b1;
            set_key(j, K128B);
         end
         if (repulse && lat == 11) start[j] = 1'b0;
      end while (done[j] !== 1'b1 && lat < 200);
      chk_val($sformatf("latency[%0d]", j), 128'(lat), 128'(exp_lat));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1919:0] ref_flat;

      build_sbox();
      chk_val("model_sbox_00", {120'b0, sb[0]}, 128'h63);
      chk_val("model_sbox_53", {120'b0, sb[8'h53]}, 128'hed);
      model_expand(4, K128, ref_flat);
      chk_val("model_128_w4", {96'b0, ref_flat[224 +: 32]}, 128'ha0fafe17);
      chk_val("model_128_rk10", ref_flat[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      model_expand(4, K128B, ref_flat);
      chk_val("model_128b_rk10", ref_flat[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      model_expand(6, K192, ref_flat);
      chk_val("model_192_rk12", ref_flat[1536 +: 128], 128'he98ba06f448c773c8ecc720401002202);
      model_expand(8, K256, ref_flat);
      chk_val("model_256_rk14", ref_flat[1792 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);

      #1 rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;

      // AES-128 with a second start ignored mid-expansion
      run(0, K128, 41, 1'b1);
      chk_val("dut128_w4", {96'b0, w128[224 +: 32]}, 128'ha0fafe17);
      chk_val("dut128_rk10", w128[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Restart directly from DONE
      run(0, K128B, 41, 1'b0);
      chk_val("dut128b_rk10", w128[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      run(1, K192, 47, 1'b0);
      chk_val("dut192_rk12", w192[1536 +: 128], 128'he98ba06f448c773c8ecc720401002202);

      run(2, K256, 53, 1'b0);
      chk_val("dut256_rk14", w256[1792 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);

      // Abort AES-128 mid-run with an asynchronous reset
      set_key(0, K128);
      start[0] = 1'b1;
      cycle();
      start[0] = 1'b0;
      repeat (19) cycle();
      rst = 1'b1;
      #1;
      chk_bit("rst_busy", 0, busy[0], 1'b0);
      chk_bit("rst_done", 0, done[0], 1'b0);
      chk_w("rst_w", 0, wx[0], '0);
      chk_w("rst_w", 2, wx[2], '0);
      repeat (2) cycle();
      rst = 1'b0;

      run(0, K128, 41, 1'b0);
      chk_val("dut128_after_rst_w4", {96'b0, w128[224 +: 32]}, 128'ha0fafe17);
      chk_val("dut128_after_rst_rk10", w128[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      repeat (2) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 Parameter: Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
REQ-002 Parameter: Nr, 10, number of rounds; SHALL equal Nk+6.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to expand key_in; sampled only in IDLE or DONE.
REQ-006 key_in  input  32*Nk  cipher key; FIPS-197 word 0 in the most-significant 32 bits.
REQ-007 busy  output  1  high while in EXPAND.
REQ-008 done  output  1  high while in DONE; w is complete and stable.
REQ-009 w  output  128*(Nr+1)  expanded schedule; round key r at w[128*r +: 128].
REQ-010 Word i of the schedule SHALL sit at w[128*(i/4) + 32*(3 - i%4) +: 32], with word 4r in the MSBs of round key r.

Function
REQ-011 FSM states SHALL be IDLE, EXPAND and DONE.
REQ-012 IDLE or DONE with start=1: key_in SHALL be latched into words 0..Nk-1, with index i<=Nk and rcon<=8'h01; next state is EXPAND.
REQ-013 The key SHALL be captured on the start edge only; key_in changes afterwards SHALL have no effect.
REQ-014 EXPAND: exactly one word per cycle, word i = word(i-Nk) XOR temp, then i<=i+1.
REQ-015 temp SHALL be word(i-1), with the following exceptions.
REQ-016 If i%Nk==0, temp SHALL be SubWord(RotWord(word(i-1))) XOR {rcon,24'h0}, and rcon SHALL then advance by xtime (01,02,04,08,10,20,40,80,1B,36).
REQ-017 If Nk==8 and i%Nk==4, temp SHALL be SubWord(word(i-1)).
REQ-018 When word 4*(Nr+1)-1 is written, next state SHALL be DONE.
REQ-019 Latency from the start edge to the first cycle with done=1 SHALL be 4*(Nr+1)-Nk+1 clocks (AES-128: 41, AES-192: 47, AES-256: 53).
REQ-020 start asserted during EXPAND SHALL be ignored; the expansion continues unaffected.
REQ-021 start in DONE SHALL restart expansion: done falls and busy rises on the same edge.
REQ-022 w words not yet written in the current run SHALL hold their previous values; consumers SHALL use w only while done=1.
REQ-023 busy and done SHALL never be high together, and both SHALL be registered outputs.
REQ-024 SubWord SHALL apply the AES forward S-box to each of the 4 bytes, combinationally within the cycle.
REQ-025 Word selection by i SHALL use only in-range indices; no out-of-range part-selects.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, w=0, i=0 and rcon=8'h01, regardless of clk.
REQ-027 rst asserted mid-EXPAND SHALL abort the run; a new start is required after release.
REQ-028 The first start edge after rst deasserts SHALL be honoured.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the S-box table, the xtime function and the legal Nk/Nr pairs.
REQ-030 One sub-module, sub_word (32-bit in, 32-bit out, four S-box lookups), SHALL be instantiated once.
REQ-031 The block SHALL contain no other hierarchy.

Verification
REQ-032 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> word 4=a0fafe17, round key 10=d014f9a8c9ee2589e13f0cc8b6630ca6, done at cycle 41.
REQ-033 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> round key 12=e98ba06f448c773c8ecc720401002202, done at cycle 47.
REQ-034 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round key 14=fe4890d1e6188d0b046df344706c631e, done at cycle 53.
REQ-035 AES-128, start pulsed again at cycle 10 with a different key_in -> ignored; REQ-032 results unchanged.
REQ-036 rst pulsed mid-EXPAND at cycle 20 -> w=0, busy=0, done=0 immediately; a following start with the REQ-032 key reproduces REQ-032 results.
REQ-037 Back-to-back: start in DONE with key 000102030405060708090a0b0c0d0e0f -> round key 10=13111d7fe3944a17f307a78b4d2b30c5.
